// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, FSM states and the default data width.
package alu_arb_pkg;

    localparam int ALU_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant: on a tie, the requester that did not win last time is granted.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (i_advance) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared add/sub/mul ALU; one op in flight, tagged response.
// Optional signed-overflow flag on the response is enabled with `define ALU_ARB_OVF_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [1:0]       i_req0_op,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [1:0]       i_req1_op,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_result,
`ifdef ALU_ARB_OVF_EN
    output logic             o_rsp_ovf,
`endif
    output logic [WIDTH-1:0] o_alu_first,
    output logic [WIDTH-1:0] o_alu_second,
    output logic             o_alu_mul,
    output logic             o_alu_sub,
    input  logic [WIDTH-1:0] i_alu_result
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       w_grant;
    logic             w_hs;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [WIDTH-1:0] r_result;

    rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     ({i_req1_valid, i_req0_valid}),
        .i_advance (w_hs),
        .o_grant   (w_grant)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_hs         = 1'b0;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_rsp_valid  = 1'b0;
        o_alu_mul    = 1'b0;
        o_alu_sub    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Readies are forced low while reset is held, even with requests pending.
                o_req0_ready = w_grant[0] & ~i_rst;
                o_req1_ready = w_grant[1] & ~i_rst;
                w_hs         = |w_grant;
                if (w_hs) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                o_alu_mul = r_op[1];
                o_alu_sub = ~r_op[1] & r_op[0];
                w_next    = S_DONE;
            end
            S_DONE: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_hs) begin
                r_id <= w_grant[1];
                if (w_grant[1]) begin
                    r_op <= i_req1_op;
                    r_a  <= i_req1_a;
                    r_b  <= i_req1_b;
                end else begin
                    r_op <= i_req0_op;
                    r_a  <= i_req0_a;
                    r_b  <= i_req0_b;
                end
            end
            if (r_state == S_EXEC) begin
                r_result <= i_alu_result;
            end
        end
    end

`ifdef ALU_ARB_OVF_EN
    logic r_ovf;

    function automatic logic ovf_calc(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0]   s;
        logic [2*WIDTH-1:0] p;
        logic               ovf;
        s   = '0;
        p   = '0;
        ovf = 1'b0;
        if (op[1]) begin
            p   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
            // Overflow unless the upper half is a pure sign extension of the low half.
            ovf = (p != {{WIDTH{p[WIDTH-1]}}, p[WIDTH-1:0]});
        end else if (op == OP_SUB) begin
            s   = a - b;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end else begin
            s   = a + b;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end
        return ovf;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_ovf <= ovf_calc(r_op, r_a, r_b);
        end
    end

    assign o_rsp_ovf = r_ovf;
`endif

    assign o_alu_first  = r_a;
    assign o_alu_second = r_b;
    assign o_rsp_id     = r_id;
    assign o_rsp_result = r_result;

endmodule
